// File: rtl/pdu_hex_input_pkg.sv
// Debug-unit constants shared by the hex-entry front end, plus the
// 16-to-4 highest-index-wins priority encoder.
package pdu_hex_input_pkg;
    localparam int PDU_DIGITS           = 8;
    localparam int PDU_DATA_W           = 32;
    localparam int PDU_KEYS             = 16;
    localparam int PDU_DEBOUNCE_DEFAULT = 1000000;  // 10 ms at 100 MHz

    function automatic logic [3:0] prio_enc16(input logic [15:0] v);
        logic [3:0] r;
        r = 4'h0;
        for (int i = 0; i < 16; i++)
            if (v[i]) r = 4'(i);
        return r;
    endfunction
endpackage

// File: rtl/pdu_hex_input_if.sv
// Key/delete/clear inputs and entered-value outputs of the hex-entry block.
interface pdu_hex_input_if;
    import pdu_hex_input_pkg::*;
    logic [PDU_KEYS-1:0]   x;
    logic                  del;
    logic                  clr;
    logic [PDU_DATA_W-1:0] data;
    logic [3:0]            digit;
    logic                  x_p;
    logic                  del_p;
    logic [3:0]            count;

    modport master (output x, del, clr, input data, digit, x_p, del_p, count);
    modport slave  (input x, del, clr, output data, digit, x_p, del_p, count);
endinterface

// File: rtl/pdu_debounce.sv
// Synchronise, tick-sampled debounce and rising-edge detect for W raw inputs.
// A bit is accepted only after it reads identically on two consecutive ticks.
module pdu_debounce #(
    parameter int W               = 17,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] raw,
    output logic [W-1:0] stable,
    output logic [W-1:0] rise
);
    logic [W-1:0]     sync1, sync2, samp, stable_d, eq;
    logic [CNT_W-1:0] cnt;
    logic             tick;

    assign tick = (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign eq   = ~(sync2 ^ samp);
    assign rise = stable & ~stable_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            sync1    <= '0;
            sync2    <= '0;
            samp     <= '0;
            stable   <= '0;
            stable_d <= '0;
        end else begin
            cnt      <= tick ? '0 : cnt + CNT_W'(1);
            sync1    <= raw;
            sync2    <= sync1;
            stable_d <= stable;
            if (tick) begin
                samp   <= sync2;
                stable <= (samp & eq) | (stable & ~eq);
            end
        end
    end
endmodule

// File: rtl/pdu_hex_input.sv
// Hex-key entry: debounced key/delete edges shift nibbles into a 32-bit value.
// clr beats delete, which beats any key; the highest-numbered key wins a tie.
module pdu_hex_input
    import pdu_hex_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = PDU_DEBOUNCE_DEFAULT,
    parameter int CNT_W           = 20
) (
    input  logic           clk,
    input  logic           rst,
    pdu_hex_input_if.slave bus
);
    logic [PDU_KEYS:0]     rise;
    logic [PDU_KEYS-1:0]   key_r;
    logic                  del_r;
    logic [3:0]            d;
    logic [PDU_DATA_W-1:0] data_q;
    logic [3:0]            digit_q, count_q;
    logic                  x_p_q, del_p_q;

    pdu_debounce #(
        .W(PDU_KEYS + 1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)
    ) u_deb (
        .clk(clk), .rst(rst), .raw({bus.del, bus.x}), .stable(), .rise(rise)
    );

    assign key_r = rise[PDU_KEYS-1:0];
    assign del_r = rise[PDU_KEYS];
    assign d     = prio_enc16(key_r);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            digit_q <= '0;
            count_q <= '0;
            x_p_q   <= 1'b0;
            del_p_q <= 1'b0;
        end else begin
            x_p_q   <= 1'b0;
            del_p_q <= 1'b0;
            if (bus.clr) begin
                data_q  <= '0;
                count_q <= '0;
            end else if (del_r) begin
                data_q  <= {4'h0, data_q[PDU_DATA_W-1:4]};
                if (count_q != 4'd0) count_q <= count_q - 4'd1;
                del_p_q <= 1'b1;
            end else if (|key_r) begin
                data_q  <= {data_q[PDU_DATA_W-5:0], d};
                digit_q <= d;
                x_p_q   <= 1'b1;
                if (count_q < 4'(PDU_DIGITS)) count_q <= count_q + 4'd1;
            end
        end
    end

    assign bus.data  = data_q;
    assign bus.digit = digit_q;
    assign bus.count = count_q;
    assign bus.x_p   = x_p_q;
    assign bus.del_p = del_p_q;
endmodule

// File: tb/tb_pdu_hex_input.sv
// Directed bench for pdu_hex_input with a 4-cycle debounce interval.
module tb_pdu_hex_input;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   nxp_tot = 0;
    int   ndp_tot = 0;

    pdu_hex_input_if bus();

    pdu_hex_input #(.DEBOUNCE_CYCLES(4), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    // every cycle with a pulse high counts once, so a stuck pulse shows up as extras
    always @(negedge clk) begin
        if (bus.x_p)   nxp_tot++;
        if (bus.del_p) ndp_tot++;
    end

    typedef struct {
        logic [15:0] x;
        logic        del;
        logic        clr;
        logic [31:0] data;
        logic [3:0]  cnt;
        logic [3:0]  dig;
        int          nxp;
        int          ndp;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string name, input logic [31:0] dat, input logic [3:0] cnt,
                             input logic [3:0] dig, input int xp0, input int dp0,
                             input int nxp, input int ndp);
        @(negedge clk);
        chk({name, " data"},  bus.data, dat);
        chk({name, " count"}, 32'(bus.count), 32'(cnt));
        chk({name, " digit"}, 32'(bus.digit), 32'(dig));
        chk({name, " x_p n"}, 32'(nxp_tot - xp0), 32'(nxp));
        chk({name, " del_p n"}, 32'(ndp_tot - dp0), 32'(ndp));
    endtask

    task automatic add(input logic [15:0] x, input logic del, input logic clr,
                       input logic [31:0] data, input logic [3:0] cnt, input logic [3:0] dig,
                       input int nxp, input int ndp);
        vec_t v;
        v.x = x; v.del = del; v.clr = clr; v.data = data;
        v.cnt = cnt; v.dig = dig; v.nxp = nxp; v.ndp = ndp;
        vt.push_back(v);
    endtask

    initial begin
        int xp0, dp0;
        bit ok;
        // key entry 1..9
        add(16'h0002, 0, 0, 32'h00000001, 1, 4'h1, 1, 0);
        add(16'h0004, 0, 0, 32'h00000012, 2, 4'h2, 1, 0);
        add(16'h0008, 0, 0, 32'h00000123, 3, 4'h3, 1, 0);
        add(16'h0010, 0, 0, 32'h00001234, 4, 4'h4, 1, 0);
        add(16'h0020, 0, 0, 32'h00012345, 5, 4'h5, 1, 0);
        add(16'h0040, 0, 0, 32'h00123456, 6, 4'h6, 1, 0);
        add(16'h0080, 0, 0, 32'h01234567, 7, 4'h7, 1, 0);
        add(16'h0100, 0, 0, 32'h12345678, 8, 4'h8, 1, 0);
        add(16'h0200, 0, 0, 32'h23456789, 8, 4'h9, 1, 0);
        add(16'h0000, 0, 1, 32'h00000000, 0, 4'h9, 0, 0);
        // build 0xAB5, then delete down past zero
        add(16'h0400, 0, 0, 32'h0000000A, 1, 4'hA, 1, 0);
        add(16'h0800, 0, 0, 32'h000000AB, 2, 4'hB, 1, 0);
        add(16'h0020, 0, 0, 32'h00000AB5, 3, 4'h5, 1, 0);
        add(16'h0000, 1, 0, 32'h000000AB, 2, 4'h5, 0, 1);
        add(16'h0000, 1, 0, 32'h0000000A, 1, 4'h5, 0, 1);
        add(16'h0000, 1, 0, 32'h00000000, 0, 4'h5, 0, 1);
        add(16'h0000, 1, 0, 32'h00000000, 0, 4'h5, 0, 1);
        // simultaneous keys, del beats key, clr beats key
        add(16'h1008, 0, 0, 32'h0000000C, 1, 4'hC, 1, 0);
        add(16'h0020, 1, 0, 32'h00000000, 0, 4'hC, 0, 1);
        add(16'h0080, 0, 0, 32'h00000007, 1, 4'h7, 1, 0);
        add(16'h0200, 0, 1, 32'h00000000, 0, 4'h7, 0, 0);

        bus.x = '0; bus.del = 1'b0; bus.clr = 1'b0;
        cyc(3);
        @(negedge clk);
        chk("reset outputs", {bus.data[27:0], bus.x_p, bus.del_p, 2'b00} | 32'(bus.count) | 32'(bus.digit), 32'h0);
        chk("reset data", bus.data, 32'h0);
        @(posedge clk); #2 rst = 1'b0;
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.data != 0 || bus.count != 0 || bus.digit != 0 || bus.x_p || bus.del_p) ok = 1'b0;
        end
        chk("idle after reset", 32'(ok), 32'h1);

        foreach (vt[i]) begin
            xp0 = nxp_tot; dp0 = ndp_tot;
            cyc(1);
            bus.x = vt[i].x; bus.del = vt[i].del; bus.clr = vt[i].clr;
            cyc(12);
            bus.x = '0; bus.del = 1'b0;
            cyc(12);
            bus.clr = 1'b0;
            chk_state($sformatf("vec%0d", i), vt[i].data, vt[i].cnt, vt[i].dig, xp0, dp0,
                      vt[i].nxp, vt[i].ndp);
        end

        // long hold: exactly one pulse, none on release
        xp0 = nxp_tot; dp0 = ndp_tot;
        bus.x = 16'h8000; cyc(100);
        chk_state("hold F", 32'h0000000F, 1, 4'hF, xp0, dp0, 1, 0);
        bus.x = '0; cyc(24);
        chk_state("release F", 32'h0000000F, 1, 4'hF, xp0, dp0, 1, 0);

        // bouncing key 7 settles high
        xp0 = nxp_tot; dp0 = ndp_tot;
        repeat (10) begin bus.x[7] = ~bus.x[7]; cyc(2); end
        bus.x[7] = 1'b1; cyc(24);
        bus.x[7] = 1'b0; cyc(24);
        chk_state("bounce 7", 32'h000000F7, 2, 4'h7, xp0, dp0, 1, 0);

        // short glitch on key 2 is rejected
        xp0 = nxp_tot; dp0 = ndp_tot;
        bus.x[2] = 1'b1; cyc(3);
        bus.x[2] = 1'b0; cyc(24);
        chk_state("glitch 2", 32'h000000F7, 2, 4'h7, xp0, dp0, 0, 0);

        // async reset mid-cycle with key F held, then accepted once after release
        bus.x = 16'h8000; cyc(5);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        chk("async rst data", bus.data, 32'h0);
        chk("async rst misc", {20'h0, bus.count, bus.digit, 2'b00, bus.x_p, bus.del_p}, 32'h0);
        cyc(3);
        xp0 = nxp_tot; dp0 = ndp_tot;
        #2 rst = 1'b0;
        cyc(30);
        chk_state("held through reset", 32'h0000000F, 1, 4'hF, xp0, dp0, 1, 0);
        bus.x = '0; cyc(24);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pdu_hex_input.md
Name: pdu_hex_input

Overview:
- Debug-unit front end that turns 16 hex-key switches plus a delete button into a 32-bit hex value for the debug unit's address/data entry.
- Synchronises and debounces all inputs, then detects rising edges.
- Selects one digit per event by highest-index priority encoding and shifts it into an 8-nibble register.
- Output feeds the debug-unit FSM, which reads `data` and issues `clr` after consuming it.

Parameters:
- DEBOUNCE_CYCLES, 1000000, clk cycles between debounce samples (10 ms at 100 MHz); minimum 2; benches use 4.
- CNT_W, 20, width of the sample-interval counter; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- x  in  16  raw hex-key switches; x[i] high means key i pressed; asynchronous to clk
- del  in  1  raw delete button; asynchronous to clk
- clr  in  1  synchronous clear request from the debug-unit FSM; already synchronous to clk
- data  out  32  entered value; newest digit in data[3:0]
- digit  out  4  last accepted digit
- x_p  out  1  one-cycle pulse: a digit was accepted this cycle
- del_p  out  1  one-cycle pulse: a delete was accepted this cycle
- count  out  4  number of digits currently held, 0..8

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. While rst is high, all registers are 0, including:
  - synchroniser and debounce state, and the tick counter;
  - outputs data=0, digit=0, x_p=0, del_p=0, count=0.
- Synchroniser: 2-flop synchroniser on each of x[15:0] and del (17 bits).
- Tick counter:
  - Counts 0..DEBOUNCE_CYCLES-1 and wraps.
  - tick=1 for the single cycle in which the counter equals DEBOUNCE_CYCLES-1.
  - Free-running; clr does not affect it.
- Debounce, evaluated on tick only:
  - samp <= sync.
  - stable[i] <= samp[i] if sync[i]==samp[i]; otherwise stable[i] holds.
  - An input must therefore be identical on two consecutive ticks before it is accepted.
- Edge detect:
  - rise = stable & ~stable_d, where stable_d is stable delayed one cycle.
  - rise is non-zero for at most one cycle per transition.
  - Falling edges are ignored. A held key produces no repeat.
- Event priority per cycle, highest first:
  1. clr: data<=0, count<=0. x_p=0, del_p=0. Any simultaneous rise is discarded.
  2. del rise: data<={4'h0, data[31:4]}; count<=count-1 if count>0, else stays 0; del_p=1. Any simultaneous key rise is discarded.
  3. Key rise (rise[15:0] != 0):
     - d = index of the highest set bit of rise[15:0]; lower simultaneous rises are discarded.
     - data<={data[27:0], d}; digit<=d; x_p=1.
     - count<=count+1 if count<8, else stays 8. The oldest nibble shifts out when count==8.
- Outputs:
  - x_p and del_p are registered, high exactly one cycle, coincident with the data update.
  - digit updates only on an accepted key and holds otherwise.
- Latency from a stable raw change to the x_p/del_p pulse:
  - 2 synchroniser cycles, plus 1 to 2 ticks for debounce, plus 2 cycles (edge register and output register).
  - Worst case is 2*DEBOUNCE_CYCLES+4 cycles.
- Bounce rejection: a glitch shorter than one tick interval never reaches stable.
- Reset mid-operation: asynchronous; all state returns to 0 immediately. A key still held after reset release is accepted once its stable value rises from 0.

Decomposition:
- Shared debug-unit package holds:
  - PDU_DIGITS=8, PDU_DATA_W=32, PDU_KEYS=16;
  - the default DEBOUNCE_CYCLES for 100 MHz.
- One natural sub-module: pdu_debounce, parameterised by width. It contains the synchroniser, samp, stable and stable_d, and outputs stable plus rise.
  - Instantiated once with width 17.
  - It shares one tick counter, which lives in pdu_debounce.
- Digit selection uses the team's existing 16-to-4 highest-index-wins priority encoder on rise[15:0].
- The top level contains only the event-priority logic and the output registers.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: assert rst asynchronously mid-cycle -> all outputs 0 before the next clk edge. Release rst with all inputs low -> outputs stay 0 for 20 cycles.
- Entry: press and release keys 1,2,3,4,5,6,7,8,9 in order, each held 12 cycles with a 12-cycle gap ->
  - nine x_p pulses, one cycle each;
  - data=0x23456789, count=8, digit=9.
- Delete: from data=0x00000AB5, count=3, pulse del for 12 cycles -> del_p once, data=0x000000AB, count=2. Three more deletes -> data=0, count=0, del_p each time.
- Simultaneous and priority:
  - Keys 3 and 12 rise in the same cycle -> one x_p, digit=0xC.
  - del and key 5 stable-rise together -> del_p only, no x_p.
  - clr asserted in the same cycle as a key rise -> data=0, count=0, neither pulse.
- Bounce: toggle x[7] every 2 cycles for 20 cycles, then leave it high -> exactly one x_p with digit=7. A 3-cycle glitch on x[2] -> no x_p.
- Hold and release: hold key 0xF for 100 cycles -> exactly one x_p with digit=0xF. Release -> no pulse.
